csr_commit: RTL and testbench

Writeback-stage commit unit for the LoongArch pipeline: the initiator side of the CSR register file's access and exception port. It holds the instruction leaving MEM in a one-entry stage register and resolves exception, interrupt and `ertn` priority. It then drives the CSR read/write port and the `wb_ex` / `eret_flush` commit strobes, and issues a pipeline flush with redirect PC. It also writes the GPR file, returning the old CSR value for `csrrd`, `csrwr` and `csrxchg`.

---
 rtl/csr_commit_pkg.sv | 52 +++++
 rtl/csr_ex_arb.sv | 33 +++
 rtl/csr_commit.sv | 126 ++++++++++++
 tb/tb_csr_commit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_commit_pkg.sv
// csr_commit_pkg: shared encodings and the WB stage-register layout for csr_commit.
package csr_commit_pkg;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

    typedef enum logic [1:0] {
        CSR_NONE = 2'd0,
        CSR_RD   = 2'd1,
        CSR_WR   = 2'd2,
        CSR_XCHG = 2'd3
    } csr_op_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COMMIT = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    // What the instruction in WB does this cycle.
    typedef enum logic [1:0] {
        K_NONE   = 2'd0,
        K_EX     = 2'd1,
        K_ERTN   = 2'd2,
        K_NORMAL = 2'd3
    } kind_t;

    typedef struct packed {
        logic [31:0] pc;
        csr_op_t     csr_op;
        logic [13:0] csr_num;
        logic [31:0] rj_value;
        logic [31:0] rd_value;
        logic        ex;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic        ertn;
        logic        rf_we;
        logic [4:0]  dest;
        logic [31:0] result;
    } stage_t;

    // csrwr and csrxchg modify the CSR; csrrd only reads it.
    function automatic logic csr_writes(csr_op_t op);
        return (op == CSR_WR) || (op == CSR_XCHG);
    endfunction

endpackage

// File: rtl/csr_ex_arb.sv
// csr_ex_arb: interrupt / exception / ertn priority for the WB instruction (CSR_COMMIT_INT_EN enables interrupts).
module csr_ex_arb
    import csr_commit_pkg::*;
(
    input  logic       valid,
    input  logic       has_int,
    input  logic       ex,
    input  logic [5:0] ecode,
    input  logic [8:0] esubcode,
    input  logic       ertn,
    output kind_t      kind,
    output logic [5:0] wb_ecode,
    output logic [8:0] wb_esubcode
);

    logic int_req;

`ifdef CSR_COMMIT_INT_EN
    assign int_req = has_int;
`else
    logic int_unused;
    assign int_unused = has_int;
    assign int_req    = 1'b0;
`endif

    // First match wins: interrupt, then upstream exception, then ertn, else a normal commit.
    always_comb begin
        kind        = !valid ? K_NONE : (int_req || ex) ? K_EX : ertn ? K_ERTN : K_NORMAL;
        wb_ecode    = !valid ? 6'd0 : int_req ? ECODE_INT : ex ? ecode : 6'd0;
        wb_esubcode = (!valid || int_req || !ex) ? 9'd0 : esubcode;
    end

endmodule

// File: rtl/csr_commit.sv
// csr_commit: WB commit unit driving the CSR access/exception port, flush redirect and GPR writeback.
module csr_commit
    import csr_commit_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        ms_valid,
    output logic        ws_allowin,
    input  logic [31:0] ms_pc,
    input  logic [1:0]  ms_csr_op,
    input  logic [13:0] ms_csr_num,
    input  logic [31:0] ms_rj_value,
    input  logic [31:0] ms_rd_value,
    input  logic        ms_ex,
    input  logic [5:0]  ms_ecode,
    input  logic [8:0]  ms_esubcode,
    input  logic        ms_ertn,
    input  logic        ms_rf_we,
    input  logic [4:0]  ms_dest,
    input  logic [31:0] ms_result,
    input  logic        has_int,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_era,
    output logic        csr_re,
    output logic [13:0] csr_num,
    input  logic [31:0] csr_rvalue,
    output logic        csr_we,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wvalue,
    output logic        wb_ex,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [31:0] wb_pc,
    output logic        eret_flush,
    output logic        flush,
    output logic [31:0] flush_pc,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    state_t state, state_next;
    stage_t stage;
    kind_t  kind;
    logic   commit;
    logic   accept;
    logic   is_ex;
    logic   is_ertn;
    logic   is_norm;
    logic   has_csr;

    // A synchronous reset must still silence the strobes of an instruction sitting in COMMIT.
    assign commit = (state == S_COMMIT) && !reset;
    // The flushing instruction also kills whatever MEM offers alongside it.
    assign accept = ms_valid && ws_allowin && !flush;

    csr_ex_arb u_arb (
        .valid      (commit),
        .has_int    (has_int),
        .ex         (stage.ex),
        .ecode      (stage.ecode),
        .esubcode   (stage.esubcode),
        .ertn       (stage.ertn),
        .kind       (kind),
        .wb_ecode   (wb_ecode),
        .wb_esubcode(wb_esubcode)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Capture the instruction leaving MEM into the one-entry stage register.
    always_ff @(posedge clock) begin
        if (reset) begin
            stage <= '0;
        end else if (accept) begin
            stage <= '{
                pc:       ms_pc,
                csr_op:   csr_op_t'(ms_csr_op),
                csr_num:  ms_csr_num,
                rj_value: ms_rj_value,
                rd_value: ms_rd_value,
                ex:       ms_ex,
                ecode:    ms_ecode,
                esubcode: ms_esubcode,
                ertn:     ms_ertn,
                rf_we:    ms_rf_we,
                dest:     ms_dest,
                result:   ms_result
            };
        end
    end

    // Next state: a flush always leads to a one-cycle DRAIN bubble, otherwise follow the accept.
    always_comb begin
        state_next = (state == S_DRAIN) ? S_IDLE :
                     flush              ? S_DRAIN :
                     accept             ? S_COMMIT : S_IDLE;
    end

    // Commit strobes and data, all zero unless the matching commit kind is active.
    always_comb begin
        is_ex      = kind == K_EX;
        is_ertn    = kind == K_ERTN;
        is_norm    = kind == K_NORMAL;
        has_csr    = stage.csr_op != CSR_NONE;
        ws_allowin = state != S_DRAIN;
        csr_re     = is_norm && has_csr;
        csr_we     = is_norm && csr_writes(stage.csr_op);
        csr_num    = csr_re ? stage.csr_num : 14'd0;
        csr_wmask  = !csr_we ? 32'd0 : (stage.csr_op == CSR_XCHG) ? stage.rj_value : 32'hFFFF_FFFF;
        csr_wvalue = csr_we ? stage.rd_value : 32'd0;
        wb_ex      = is_ex;
        wb_pc      = is_ex ? stage.pc : 32'd0;
        eret_flush = is_ertn;
        flush      = is_ex || is_ertn;
        flush_pc   = is_ex ? csr_eentry : is_ertn ? csr_era : 32'd0;
        rf_we      = is_norm && stage.rf_we && (stage.dest != 5'd0);
        rf_waddr   = rf_we ? stage.dest : 5'd0;
        rf_wdata   = !is_norm ? 32'd0 : has_csr ? csr_rvalue : stage.result;
    end

endmodule

// File: tb/tb_csr_commit.sv
// tb_csr_commit: directed vector table plus hand sequences for csr_commit.
module tb_csr_commit;

    logic        clock = 1'b0;
    logic        reset;
    logic        ms_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic [1:0]  ms_csr_op;
    logic [13:0] ms_csr_num;
    logic [31:0] ms_rj_value;
    logic [31:0] ms_rd_value;
    logic        ms_ex;
    logic [5:0]  ms_ecode;
    logic [8:0]  ms_esubcode;
    logic        ms_ertn;
    logic        ms_rf_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_result;
    logic        has_int;
    logic [31:0] csr_eentry;
    logic [31:0] csr_era;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic        eret_flush;
    logic        flush;
    logic [31:0] flush_pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    csr_commit dut (
        .clock(clock), .reset(reset), .ms_valid(ms_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_csr_op(ms_csr_op), .ms_csr_num(ms_csr_num),
        .ms_rj_value(ms_rj_value), .ms_rd_value(ms_rd_value), .ms_ex(ms_ex),
        .ms_ecode(ms_ecode), .ms_esubcode(ms_esubcode), .ms_ertn(ms_ertn),
        .ms_rf_we(ms_rf_we), .ms_dest(ms_dest), .ms_result(ms_result),
        .has_int(has_int), .csr_eentry(csr_eentry), .csr_era(csr_era),
        .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue), .csr_we(csr_we),
        .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .wb_ex(wb_ex),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
        .eret_flush(eret_flush), .flush(flush), .flush_pc(flush_pc),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    typedef struct {
        logic [1:0]  op;
        logic [13:0] num;
        logic [31:0] rj;
        logic [31:0] rd;
        logic        ex;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic        ertn;
        logic        rfwe;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
        logic        hint;
        logic [31:0] rvalue;
        logic        e_re;
        logic        e_we;
        logic [31:0] e_wmask;
        logic [31:0] e_wvalue;
        logic        e_ex;
        logic [5:0]  e_ecode;
        logic [8:0]  e_esub;
        logic        e_eret;
        logic        e_flush;
        logic [31:0] e_fpc;
        logic        e_rfwe;
        logic [31:0] e_wdata;
    } vec_t;

    localparam int NV = 11;
    localparam logic [31:0] EENTRY = 32'h1C00_8000;
    localparam logic [31:0] ERA    = 32'h1C00_0104;

    vec_t v [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        ms_valid = 1'b0; ms_pc = '0; ms_csr_op = '0; ms_csr_num = '0; ms_rj_value = '0;
        ms_rd_value = '0; ms_ex = 1'b0; ms_ecode = '0; ms_esubcode = '0; ms_ertn = 1'b0;
        ms_rf_we = 1'b0; ms_dest = '0; ms_result = '0; has_int = 1'b0; csr_rvalue = '0;
    endtask

    task automatic offer_normal(input logic [4:0] dest, input logic [31:0] result);
        idle_inputs();
        ms_valid = 1'b1; ms_rf_we = 1'b1; ms_dest = dest; ms_result = result;
        ms_pc = 32'h1C00_0200;
    endtask

    initial begin
        v[0] = '{op:2'd2, num:14'h30, rd:32'h1234, rfwe:1'b1, dest:5'd5, rvalue:32'hAA, pc:32'h1C00_0000,
                 e_re:1'b1, e_we:1'b1, e_wmask:32'hFFFF_FFFF, e_wvalue:32'h1234,
                 e_rfwe:1'b1, e_wdata:32'hAA, default:'0};
        v[1] = '{op:2'd3, num:14'h0, rj:32'h4, rd:32'h7, rfwe:1'b1, dest:5'd3, rvalue:32'h55, pc:32'h1C00_0004,
                 e_re:1'b1, e_we:1'b1, e_wmask:32'h4, e_wvalue:32'h7, e_rfwe:1'b1, e_wdata:32'h55, default:'0};
        v[2] = '{op:2'd1, num:14'h5, rd:32'h99, rfwe:1'b1, dest:5'd7, rvalue:32'hDEAD, pc:32'h1C00_0008,
                 e_re:1'b1, e_rfwe:1'b1, e_wdata:32'hDEAD, default:'0};
        v[3] = '{rfwe:1'b1, dest:5'd9, result:32'h1122_3344, rvalue:32'hBAD, pc:32'h1C00_000C,
                 e_rfwe:1'b1, e_wdata:32'h1122_3344, default:'0};
        v[4] = '{rfwe:1'b1, dest:5'd0, result:32'h5555, pc:32'h1C00_0010, default:'0};
        v[5] = '{ex:1'b1, ecode:6'h0B, rfwe:1'b1, dest:5'd4, result:32'h77, pc:32'h1C00_0100,
                 e_ex:1'b1, e_ecode:6'h0B, e_flush:1'b1, e_fpc:EENTRY, default:'0};
        v[6] = '{op:2'd2, num:14'h30, rd:32'hF00D, ex:1'b1, ecode:6'h08, esub:9'h1, rfwe:1'b1, dest:5'd6,
                 pc:32'h1C00_0020, e_ex:1'b1, e_ecode:6'h08, e_esub:9'h1, e_flush:1'b1, e_fpc:EENTRY, default:'0};
        v[7] = '{ertn:1'b1, pc:32'h1C00_0030, e_eret:1'b1, e_flush:1'b1, e_fpc:ERA, default:'0};
        v[8] = '{ex:1'b1, ecode:6'h0D, esub:9'h3, ertn:1'b1, pc:32'h1C00_0040,
                 e_ex:1'b1, e_ecode:6'h0D, e_esub:9'h3, e_flush:1'b1, e_fpc:EENTRY, default:'0};
`ifdef CSR_COMMIT_INT_EN
        v[9] = '{op:2'd2, num:14'h30, rd:32'h1234, rfwe:1'b1, dest:5'd5, rvalue:32'hAA, hint:1'b1,
                 pc:32'h1C00_0050, e_ex:1'b1, e_ecode:6'h00, e_flush:1'b1, e_fpc:EENTRY, default:'0};
        v[10] = '{ertn:1'b1, hint:1'b1, pc:32'h1C00_0060,
                  e_ex:1'b1, e_ecode:6'h00, e_flush:1'b1, e_fpc:EENTRY, default:'0};
`else
        v[9] = '{op:2'd2, num:14'h30, rd:32'h1234, rfwe:1'b1, dest:5'd5, rvalue:32'hAA, hint:1'b1,
                 pc:32'h1C00_0050, e_re:1'b1, e_we:1'b1, e_wmask:32'hFFFF_FFFF, e_wvalue:32'h1234,
                 e_rfwe:1'b1, e_wdata:32'hAA, default:'0};
        v[10] = '{ertn:1'b1, hint:1'b1, pc:32'h1C00_0060, e_eret:1'b1, e_flush:1'b1, e_fpc:ERA, default:'0};
`endif

        csr_eentry = EENTRY;
        csr_era    = ERA;
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_allowin", {31'd0, ws_allowin}, 32'd1);
        chk("rst_strobes", {26'd0, csr_re, csr_we, wb_ex, eret_flush, flush, rf_we}, 32'd0);
        chk("rst_data", csr_wmask | csr_wvalue | wb_pc | flush_pc | rf_wdata, 32'd0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            idle_inputs();
            ms_valid = 1'b1; ms_pc = v[i].pc; ms_csr_op = v[i].op; ms_csr_num = v[i].num;
            ms_rj_value = v[i].rj; ms_rd_value = v[i].rd; ms_ex = v[i].ex; ms_ecode = v[i].ecode;
            ms_esubcode = v[i].esub; ms_ertn = v[i].ertn; ms_rf_we = v[i].rfwe; ms_dest = v[i].dest;
            ms_result = v[i].result; has_int = v[i].hint; csr_rvalue = v[i].rvalue;
            @(posedge clock);
            #1 ms_valid = 1'b0;
            @(negedge clock);
            chk($sformatf("v%0d_csr_re", i), {31'd0, csr_re}, {31'd0, v[i].e_re});
            chk($sformatf("v%0d_csr_we", i), {31'd0, csr_we}, {31'd0, v[i].e_we});
            chk($sformatf("v%0d_wb_ex", i), {31'd0, wb_ex}, {31'd0, v[i].e_ex});
            chk($sformatf("v%0d_eret", i), {31'd0, eret_flush}, {31'd0, v[i].e_eret});
            chk($sformatf("v%0d_flush", i), {31'd0, flush}, {31'd0, v[i].e_flush});
            chk($sformatf("v%0d_rf_we", i), {31'd0, rf_we}, {31'd0, v[i].e_rfwe});
            if (v[i].e_re) chk($sformatf("v%0d_csr_num", i), {18'd0, csr_num}, {18'd0, v[i].num});
            if (v[i].e_we) begin
                chk($sformatf("v%0d_wmask", i), csr_wmask, v[i].e_wmask);
                chk($sformatf("v%0d_wvalue", i), csr_wvalue, v[i].e_wvalue);
            end
            if (v[i].e_ex) begin
                chk($sformatf("v%0d_ecode", i), {26'd0, wb_ecode}, {26'd0, v[i].e_ecode});
                chk($sformatf("v%0d_esub", i), {23'd0, wb_esubcode}, {23'd0, v[i].e_esub});
                chk($sformatf("v%0d_wb_pc", i), wb_pc, v[i].pc);
            end
            if (v[i].e_flush) chk($sformatf("v%0d_flush_pc", i), flush_pc, v[i].e_fpc);
            if (v[i].e_rfwe) begin
                chk($sformatf("v%0d_rf_wdata", i), rf_wdata, v[i].e_wdata);
                chk($sformatf("v%0d_rf_waddr", i), {27'd0, rf_waddr}, {27'd0, v[i].dest});
            end
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_next_allowin", i), {31'd0, ws_allowin}, {31'd0, !v[i].e_flush});
            @(posedge clock);
        end

        // ertn followed by an instruction offered during DRAIN: it must be dropped.
        @(negedge clock);
        idle_inputs();
        ms_valid = 1'b1; ms_ertn = 1'b1; ms_pc = 32'h1C00_0070;
        @(posedge clock);
        #1 offer_normal(5'd8, 32'hCAFE);
        @(negedge clock);
        chk("drain_eret", {31'd0, eret_flush}, 32'd1);
        chk("drain_fpc", flush_pc, ERA);
        @(posedge clock);
        #1;
        chk("drain_allowin", {31'd0, ws_allowin}, 32'd0);
        @(posedge clock);
        #1 idle_inputs();
        @(negedge clock);
        chk("drain_dropped", {31'd0, rf_we}, 32'd0);
        chk("drain_back_allowin", {31'd0, ws_allowin}, 32'd1);

        // Back-to-back normal instructions commit one per cycle.
        @(negedge clock);
        offer_normal(5'd10, 32'h0000_0A0A);
        @(posedge clock);
        #1 offer_normal(5'd11, 32'h0000_0B0B);
        @(negedge clock);
        chk("b2b_0_we", {31'd0, rf_we}, 32'd1);
        chk("b2b_0_data", rf_wdata, 32'h0000_0A0A);
        @(posedge clock);
        #1 idle_inputs();
        @(negedge clock);
        chk("b2b_1_we", {31'd0, rf_we}, 32'd1);
        chk("b2b_1_data", rf_wdata, 32'h0000_0B0B);
        chk("b2b_1_addr", {27'd0, rf_waddr}, 32'd11);
        @(posedge clock);
        @(negedge clock);
        chk("b2b_end", {31'd0, rf_we}, 32'd0);

        // has_int is only looked at during COMMIT, not at capture.
        @(negedge clock);
        offer_normal(5'd12, 32'h0000_0C0C);
        has_int = 1'b1;
        @(posedge clock);
        #1 begin ms_valid = 1'b0; has_int = 1'b0; end
        @(negedge clock);
        chk("int_late_ex", {31'd0, wb_ex}, 32'd0);
        chk("int_late_we", {31'd0, rf_we}, 32'd1);
        @(posedge clock);

        // Reset asserted while a csrwr sits in COMMIT.
        @(negedge clock);
        idle_inputs();
        ms_valid = 1'b1; ms_csr_op = 2'd2; ms_csr_num = 14'h30; ms_rd_value = 32'h4321;
        ms_rf_we = 1'b1; ms_dest = 5'd5; csr_rvalue = 32'hAA;
        @(posedge clock);
        #1 begin ms_valid = 1'b0; reset = 1'b1; end
        @(negedge clock);
        chk("rstc_strobes", {26'd0, csr_re, csr_we, wb_ex, eret_flush, flush, rf_we}, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rstc_after_strobes", {26'd0, csr_re, csr_we, wb_ex, eret_flush, flush, rf_we}, 32'd0);
        chk("rstc_after_allowin", {31'd0, ws_allowin}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
